range_counter_sched: RTL



---
 rtl/range_counter_sched_if.sv | 18 +
 rtl/range_counter_sched.sv | 130 +++++++++++++
 2 files changed

// File: rtl/range_counter_sched_if.sv
// Request/grant bus between the per-channel sequencers and the shared range counter.
interface range_counter_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [OW-1:0]     owner;
  logic              busy;
  logic [W-1:0]      count;
  logic              done;

  modport master (output req, data, input gnt, owner, busy, count, done);
  modport slave  (input req, data, output gnt, owner, busy, count, done);
endinterface

// File: rtl/range_counter_sched.sv
// Shares one LO..HI wrapping up-counter among NREQ requesters, one session per grant.
// Define RANGE_SCHED_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module range_counter_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned LO   = 3,
  parameter int unsigned HI   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  range_counter_sched_if.slave bus
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    count_q, count_nxt;
  logic [NREQ-1:0] gnt_q, gnt_nxt;
  logic [OW-1:0]   owner_q, owner_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic [OW-1:0]   win;
  logic            found;
  logic [W-1:0]    win_data;
  logic [W-1:0]    load_val;
  logic            at_hi;
  int unsigned     idx;
`ifdef RANGE_SCHED_RR_EN
  logic [OW-1:0]   rr_q, rr_nxt;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= W'(LO);
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RANGE_SCHED_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      gnt_q   <= gnt_nxt;
      owner_q <= owner_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
`ifdef RANGE_SCHED_RR_EN
      rr_q    <= rr_nxt;
`endif
    end
  end

  // Winner: first asserted request scanning upward from the start point
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef RANGE_SCHED_RR_EN
      idx = (32'(rr_q) + i) % NREQ;
`else
      idx = i;
`endif
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  assign win_data = bus.data[32'(win)*W +: W];
  assign load_val = (win_data >= W'(LO) && win_data <= W'(HI)) ? win_data : W'(LO);
  assign at_hi    = (count_q == W'(HI));

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = RUN;
      RUN:     if (at_hi)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    count_nxt = count_q;
    gnt_nxt   = '0;
    owner_nxt = owner_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
`ifdef RANGE_SCHED_RR_EN
    rr_nxt    = rr_q;
`endif
    case (state)
      IDLE: begin
        if (|bus.req) begin
          gnt_nxt   = NREQ'(1) << win;
          owner_nxt = win;
          busy_nxt  = 1'b1;
          count_nxt = load_val;
`ifdef RANGE_SCHED_RR_EN
          rr_nxt    = OW'((32'(win) + 1) % NREQ);
`endif
        end
      end
      RUN: begin
        if (at_hi) begin
          count_nxt = W'(LO);
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          count_nxt = count_q + W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.done  = done_q;
endmodule
